// File: rtl/spi_master_arb.sv
// Round-robin arbiter in front of an SPI byte shifter: each granted requester gets a
// command byte, a data byte, a completion pulse, and a programmable ss-high gap afterwards.
module spi_master_arb #(
    parameter int N  = 2,
    parameter int GW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_en,
    input  logic [GW-1:0]    gap,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   req_cmd,
    input  logic [8*N-1:0]   req_wdata,
    output logic [N-1:0]     done,
    output logic [7:0]       rdata,
    output logic             busy,
    output logic             ss,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    input  logic             byte_done,
    input  logic [7:0]       byte_rdata,
    output logic [2:0]       state_dbg
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CMD   = 3'd2,
        DATA  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   grant_q;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand_idx;
    logic            win_found;
    logic            arb_fire;
    logic [7:0]      cmd_q;
    logic [7:0]      wdata_q;
    logic [7:0]      data_byte;
    logic [GW-1:0]   gap_cnt;
    logic            bv_n;
    logic [7:0]      bd_n;
    logic            byte_ack;

    // grant_q doubles as last_grant: the search starts one past the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            cand_idx = IW'((int'(grant_q) + i) % N);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign data_byte = (cmd_q[7:6] == 2'b00) ? wdata_q : 8'h00;

    // Shifter handshake: byte_valid/byte_data are held until the cycle byte_done is seen
    // with byte_valid high; byte_valid then drops for at least one cycle before the next byte.
    assign byte_ack = byte_valid && byte_done;

    always_comb begin
        state_n  = state;
        arb_fire = 1'b0;
        bv_n     = 1'b0;
        bd_n     = byte_data;
        case (state)
            IDLE: begin
                if (spi_en && win_found) begin
                    arb_fire = 1'b1;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                state_n = CMD;
                bv_n    = 1'b1;
                bd_n    = cmd_q;
            end
            CMD: begin
                if (byte_ack) begin
                    state_n = DATA;
                    bd_n    = data_byte;
                end else begin
                    bv_n = 1'b1;
                end
            end
            DATA: begin
                if (byte_ack) state_n = HOLD;
                else          bv_n    = 1'b1;
            end
            HOLD: state_n = GAP;
            GAP: begin
                // Re-arbitrate on the last gap cycle so back-to-back grants keep ss high gap+1 cycles.
                if (gap_cnt == '0) begin
                    if (spi_en && win_found) begin
                        arb_fire = 1'b1;
                        state_n  = SETUP;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= IW'(N - 1);
            cmd_q      <= '0;
            wdata_q    <= '0;
            gap_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            done       <= '0;
            rdata      <= '0;
        end else begin
            state      <= state_n;
            byte_valid <= bv_n;
            byte_data  <= bd_n;
            done       <= '0;
            if (state == HOLD) done[grant_q] <= 1'b1;
            if (arb_fire) begin
                grant_q <= win_idx;
                cmd_q   <= req_cmd[{win_idx, 3'b000} +: 8];
                wdata_q <= req_wdata[{win_idx, 3'b000} +: 8];
            end
            if (state == HOLD)
                gap_cnt <= gap;
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            if (state == DATA && byte_ack) rdata <= byte_rdata;
        end
    end

    assign ss        = (state == IDLE) || (state == GAP);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
